hamm_secded_decoder: RTL and testbench

//  Parametrised extended-Hamming SECDED decoder for codewords of 8/16/32/64 bits.

---
 rtl/hamm_secded_decoder_if.sv | 38 +++
 rtl/hamm_secded_decoder.sv | 172 +++++++++++++++++
 tb/tb_hamm_secded_decoder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/hamm_secded_decoder_if.sv
// Stream and status bundle for the extended-Hamming SECDED decoder.
// slave is the decoder's view; master is the source/sink side.
interface hamm_secded_decoder_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
);
    localparam int N = (DATA_W == 4)  ? 8  :
                       (DATA_W == 11) ? 16 :
                       (DATA_W == 26) ? 32 :
                       (DATA_W == 57) ? 64 : 8;
    localparam int R = $clog2(N);

    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      code_in;
    logic              correct_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_corr;
    logic              out_uncorr;
    logic [R-1:0]      out_errpos;
    logic              clr_cnt;
    logic [CNT_W-1:0]  corr_cnt;
    logic [CNT_W-1:0]  uncorr_cnt;

    modport slave (
        input  in_valid, code_in, correct_en, out_ready, clr_cnt,
        output in_ready, out_valid, out_data, out_corr, out_uncorr, out_errpos,
               corr_cnt, uncorr_cnt
    );

    modport master (
        output in_valid, code_in, correct_en, out_ready, clr_cnt,
        input  in_ready, out_valid, out_data, out_corr, out_uncorr, out_errpos,
               corr_cnt, uncorr_cnt
    );
endinterface

// File: rtl/hamm_secded_decoder.sv
// Extended-Hamming SECDED decoder: stage 1 captures codeword and syndrome,
// stage 2 classifies, optionally corrects and extracts data; saturating error counters.
module hamm_secded_decoder #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    hamm_secded_decoder_if.slave  bus
);
    localparam bit LEGAL = (DATA_W == 4) || (DATA_W == 11) ||
                           (DATA_W == 26) || (DATA_W == 57);
    localparam int N = (DATA_W == 4)  ? 8  :
                       (DATA_W == 11) ? 16 :
                       (DATA_W == 26) ? 32 :
                       (DATA_W == 57) ? 64 : 8;
    localparam int R = $clog2(N);

    if (!LEGAL) begin : g_bad_data_w
        $error("hamm_secded_decoder: DATA_W must be 4, 11, 26 or 57");
    end

    // Positions whose index has bit b set feed syndrome bit b.
    function automatic logic [N-1:0] syn_mask(input int b);
        logic [N-1:0] m;
        m = '0;
        for (int i = 1; i < N; i++) m[i] = ((i >> b) & 1) == 1;
        return m;
    endfunction

    // k-th non-power-of-two position at or above 3 carries data bit k.
    function automatic int data_pos(input int k);
        int cnt;
        int pos;
        cnt = 0;
        pos = 0;
        for (int i = 3; i < N; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == k) pos = i;
                cnt++;
            end
        end
        return pos;
    endfunction

    logic              s1_valid_q, s1_valid_d;
    logic [N-1:0]      s1_code_q, s1_code_d;
    logic [R-1:0]      s1_syn_q, s1_syn_d;
    logic              s1_par_q, s1_par_d;
    logic              s1_cen_q, s1_cen_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_corr_q, out_corr_d;
    logic              out_uncorr_q, out_uncorr_d;
    logic [R-1:0]      out_errpos_q, out_errpos_d;

    logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

    logic [R-1:0]      syn_in;
    logic [N-1:0]      fixed;
    logic [DATA_W-1:0] data_ext;
    logic              s2_load;
    logic              in_ready;
    logic              deliver;

    for (genvar b = 0; b < R; b++) begin : g_syn
        assign syn_in[b] = ^(bus.code_in & syn_mask(b));
    end

    for (genvar k = 0; k < DATA_W; k++) begin : g_ext
        assign data_ext[k] = fixed[data_pos(k)];
    end

    // Syndrome 0 with odd parity flips only the overall parity bit, leaving data intact.
    always_comb begin
        fixed = s1_code_q;
        if (s1_par_q && s1_cen_q) fixed[s1_syn_q] = ~s1_code_q[s1_syn_q];
    end

    assign s2_load  = !out_valid_q || bus.out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign deliver  = out_valid_q && bus.out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        s1_par_d   = s1_par_q;
        s1_cen_d   = s1_cen_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_code_d = bus.code_in;
                s1_syn_d  = syn_in;
                s1_par_d  = ^bus.code_in;
                s1_cen_d  = bus.correct_en;
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_corr_d   = out_corr_q;
        out_uncorr_d = out_uncorr_q;
        out_errpos_d = out_errpos_q;
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d   = data_ext;
                out_corr_d   = s1_par_q;
                out_uncorr_d = !s1_par_q && (s1_syn_q != '0);
                out_errpos_d = s1_syn_q;
            end
        end
    end

    always_comb begin
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        if (bus.clr_cnt) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (deliver) begin
            if (out_corr_q && (corr_cnt_q != {CNT_W{1'b1}}))
                corr_cnt_d = corr_cnt_q + 1'b1;
            if (out_uncorr_q && (uncorr_cnt_q != {CNT_W{1'b1}}))
                uncorr_cnt_d = uncorr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
            s1_par_q     <= 1'b0;
            s1_cen_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_corr_q   <= 1'b0;
            out_uncorr_q <= 1'b0;
            out_errpos_q <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s1_par_q     <= s1_par_d;
            s1_cen_q     <= s1_cen_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_corr_q   <= out_corr_d;
            out_uncorr_q <= out_uncorr_d;
            out_errpos_q <= out_errpos_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_corr   = out_corr_q;
    assign bus.out_uncorr = out_uncorr_q;
    assign bus.out_errpos = out_errpos_q;
    assign bus.corr_cnt   = corr_cnt_q;
    assign bus.uncorr_cnt = uncorr_cnt_q;
endmodule

// File: tb/tb_hamm_secded_decoder.sv
// Directed bench for hamm_secded_decoder (DATA_W=4, CNT_W=2) with hand-encoded codewords.
module tb_hamm_secded_decoder;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    hamm_secded_decoder_if #(.DATA_W(4), .CNT_W(2)) bus ();

    hamm_secded_decoder #(.DATA_W(4), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Valid codewords: AA->1011, 0F->0001, 33->0010, FF->1111
    logic [7:0] w_code [4] = '{8'hAA, 8'h0F, 8'h33, 8'hFF};
    logic [3:0] w_data [4] = '{4'b1011, 4'b0001, 4'b0010, 4'b1111};

    task automatic xfer(input logic [7:0] code, input logic cen, output int lat,
                        output logic [3:0] d, output logic c, output logic u,
                        output logic [2:0] ep);
        int n;
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.code_in    = code;
        bus.correct_en = cen;
        bus.out_ready  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.correct_en = ~cen;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        d  = bus.out_data;
        c  = bus.out_corr;
        u  = bus.out_uncorr;
        ep = bus.out_errpos;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.code_in = '0; bus.correct_en = 1'b1;
        bus.out_ready = 1'b1; bus.clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 4'b0) begin failures++; $display("FAIL rst_out_data got=%b exp=0000", bus.out_data); end
        checks++; if ({bus.out_corr, bus.out_uncorr} !== 2'b00) begin failures++; $display("FAIL rst_flags got=%b exp=00", {bus.out_corr, bus.out_uncorr}); end
        checks++; if (bus.out_errpos !== 3'd0) begin failures++; $display("FAIL rst_errpos got=%0d exp=0", bus.out_errpos); end
        checks++; if ({bus.corr_cnt, bus.uncorr_cnt} !== 4'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", bus.corr_cnt, bus.uncorr_cnt); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_clean;
        int lat; logic [3:0] d; logic c, u; logic [2:0] ep;
        xfer(8'hAA, 1'b1, lat, d, c, u, ep);
        checks++; if (lat !== 2) begin failures++; $display("FAIL clean_latency got=%0d exp=2", lat); end
        checks++; if (d !== 4'b1011) begin failures++; $display("FAIL clean_data got=%b exp=1011", d); end
        checks++; if ({c, u} !== 2'b00) begin failures++; $display("FAIL clean_flags got=%b exp=00", {c, u}); end
    endtask

    task automatic test_single;
        int lat; logic [3:0] d; logic c, u; logic [2:0] ep;
        xfer(8'h8A, 1'b1, lat, d, c, u, ep);
        checks++; if (d !== 4'b1011) begin failures++; $display("FAIL single_corr_data got=%b exp=1011", d); end
        checks++; if ({c, u} !== 2'b10) begin failures++; $display("FAIL single_flags got=%b exp=10", {c, u}); end
        checks++; if (ep !== 3'd5) begin failures++; $display("FAIL single_errpos got=%0d exp=5", ep); end
        checks++; if (bus.corr_cnt !== 2'd1) begin failures++; $display("FAIL single_corr_cnt got=%0d exp=1", bus.corr_cnt); end
        xfer(8'h8A, 1'b0, lat, d, c, u, ep);
        checks++; if (d !== 4'b1001) begin failures++; $display("FAIL single_raw_data got=%b exp=1001", d); end
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL single_raw_corr got=%b exp=1", c); end
    endtask

    task automatic test_parity_bit;
        int lat; logic [3:0] d; logic c, u; logic [2:0] ep;
        xfer(8'hAB, 1'b1, lat, d, c, u, ep);
        checks++; if (d !== 4'b1011) begin failures++; $display("FAIL parity_data got=%b exp=1011", d); end
        checks++; if ({c, u} !== 2'b10) begin failures++; $display("FAIL parity_flags got=%b exp=10", {c, u}); end
        checks++; if (ep !== 3'd0) begin failures++; $display("FAIL parity_errpos got=%0d exp=0", ep); end
    endtask

    task automatic test_double;
        int lat; logic [3:0] d; logic c, u; logic [2:0] ep;
        xfer(8'hAC, 1'b1, lat, d, c, u, ep);
        checks++; if ({c, u} !== 2'b01) begin failures++; $display("FAIL double_flags got=%b exp=01", {c, u}); end
        checks++; if (ep !== 3'd3) begin failures++; $display("FAIL double_errpos got=%0d exp=3", ep); end
        checks++; if (d !== 4'b1011) begin failures++; $display("FAIL double_data got=%b exp=1011", d); end
        checks++; if (bus.uncorr_cnt !== 2'd1) begin failures++; $display("FAIL double_uncorr_cnt got=%0d exp=1", bus.uncorr_cnt); end
        checks++; if (bus.corr_cnt !== 2'd3) begin failures++; $display("FAIL double_corr_cnt got=%0d exp=3", bus.corr_cnt); end
    endtask

    task automatic test_counters;
        int lat; int n; logic [3:0] d; logic c, u; logic [2:0] ep;
        @(negedge clk); bus.clr_cnt = 1'b1;
        @(negedge clk); bus.clr_cnt = 1'b0;
        checks++; if ({bus.corr_cnt, bus.uncorr_cnt} !== 4'd0) begin failures++; $display("FAIL cnt_clear got=%0d/%0d exp=0/0", bus.corr_cnt, bus.uncorr_cnt); end
        for (int i = 0; i < 5; i++) begin
            xfer(8'h8A, 1'b1, lat, d, c, u, ep);
            if (i == 1) begin
                checks++; if (bus.corr_cnt !== 2'd2) begin failures++; $display("FAIL cnt_two got=%0d exp=2", bus.corr_cnt); end
            end
        end
        checks++; if (bus.corr_cnt !== 2'd3) begin failures++; $display("FAIL cnt_saturate got=%0d exp=3", bus.corr_cnt); end
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.code_in = 8'h8A; bus.correct_en = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 10) begin @(negedge clk); n++; end
        bus.clr_cnt = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.clr_cnt = 1'b0;
        checks++; if (bus.corr_cnt !== 2'd0) begin failures++; $display("FAIL cnt_clr_wins got=%0d exp=0", bus.corr_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL cnt_clr_delivered got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_back_to_back;
        int acc; int stalls; int first; int last; logic [3:0] q[$];
        acc = 0; stalls = 0; first = -1; last = -1; q = {};
        @(negedge clk);
        bus.out_ready = 1'b1; bus.correct_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bus.in_valid = (acc < 4);
            bus.code_in  = w_code[(acc < 4) ? acc : 0];
            #1;
            if (bus.out_valid && bus.out_ready) begin
                q.push_back(bus.out_data);
                if (first < 0) first = c;
                last = c;
            end
            if (bus.in_valid && !bus.in_ready) stalls++;
            if (bus.in_valid && bus.in_ready) acc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++; if (stalls !== 0) begin failures++; $display("FAIL b2b_stalls got=%0d exp=0", stalls); end
        checks++; if (first !== 2 || last !== 5) begin failures++; $display("FAIL b2b_timing got=%0d..%0d exp=2..5", first, last); end
        checks++; if (q.size() !== 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", q.size()); end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            checks++; if (q[i] !== w_data[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%b exp=%b", i, q[i], w_data[i]); end
        end
    endtask

    task automatic test_backpressure;
        int acc; int acc_held; int unstable; logic [3:0] q[$];
        acc = 0; acc_held = -1; unstable = 0; q = {};
        @(negedge clk);
        bus.correct_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.out_ready = (c >= 5);
            bus.in_valid  = (acc < 4);
            bus.code_in   = w_code[(acc < 4) ? acc : 0];
            #1;
            if (c == 5) acc_held = acc;
            if (c >= 2 && c < 5) begin
                if (!bus.out_valid || bus.out_data !== 4'b1011 || bus.out_corr || bus.out_uncorr || bus.in_ready)
                    unstable++;
            end
            if (bus.out_valid && bus.out_ready) q.push_back(bus.out_data);
            if (bus.in_valid && bus.in_ready) acc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++; if (acc_held !== 2) begin failures++; $display("FAIL bp_accepts got=%0d exp=2", acc_held); end
        checks++; if (unstable !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", unstable); end
        checks++; if (q.size() !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", q.size()); end
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            checks++; if (q[i] !== w_data[i]) begin failures++; $display("FAIL bp_data[%0d] got=%b exp=%b", i, q[i], w_data[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int lat; int seen; logic [3:0] d; logic c, u; logic [2:0] ep;
        xfer(8'h8A, 1'b1, lat, d, c, u, ep);
        @(negedge clk);
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.code_in = 8'hAA;
        @(negedge clk);
        bus.code_in = 8'h0F;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 4'b0) begin failures++; $display("FAIL midrst_out got=%b/%b exp=0/0000", bus.out_valid, bus.out_data); end
        checks++; if ({bus.corr_cnt, bus.uncorr_cnt} !== 4'd0) begin failures++; $display("FAIL midrst_counters got=%0d/%0d exp=0/0", bus.corr_cnt, bus.uncorr_cnt); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
        seen = 0;
        repeat (3) begin
            if (bus.out_valid) seen++;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_empty got=%0d exp=0", seen); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_clean();
        test_single();
        test_parity_bit();
        test_double();
        test_counters();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
